// File: rtl/multi_key_debounce_pkg.sv
// Shared types and width helpers for the multi-key button conditioner.
// Hold-FSM states and counter-sizing functions used by every channel.
package led_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HELD   = 2'd1,
      REPEAT = 2'd2
   } holdState_e;

   // Bits needed to hold values 0..maxVal, never less than one bit.
   function automatic int cntWidth(input int maxVal);
      return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
   endfunction

   function automatic int maxOf(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/multi_key_debounce_if.sv
// Key inputs and conditioned key outputs for the multi-key button conditioner.
// The master side drives raw keys; the slave side is the conditioner itself.
interface multi_key_debounce_if #(
   parameter int N_KEYS = 4
);

   logic [N_KEYS-1:0] key;
   logic [N_KEYS-1:0] key_state;
   logic [N_KEYS-1:0] press_pulse;
   logic [N_KEYS-1:0] release_pulse;
   logic [N_KEYS-1:0] long_pulse;
   logic [N_KEYS-1:0] repeat_pulse;

   modport master (
      output key,
      input  key_state,
      input  press_pulse,
      input  release_pulse,
      input  long_pulse,
      input  repeat_pulse
   );

   modport slave (
      input  key,
      output key_state,
      output press_pulse,
      output release_pulse,
      output long_pulse,
      output repeat_pulse
   );

endinterface

// File: rtl/multi_key_debounce_chan.sv
// One push-button channel: synchroniser, stable-time debounce filter and hold FSM
// producing registered press/release/long/repeat pulses.
module key_debounce_chan
   import led_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1500000,
   parameter int LONG_CYCLES     = 50000000,
   parameter int REPEAT_CYCLES   = 10000000
) (
   input  logic clk,
   input  logic rst,
   input  logic key_i,
   output logic keyState_o,
   output logic pressPulse_o,
   output logic releasePulse_o,
   output logic longPulse_o,
   output logic repeatPulse_o
);

   localparam int DW = cntWidth(DEBOUNCE_CYCLES);
   localparam int HW = cntWidth(maxOf(LONG_CYCLES, REPEAT_CYCLES));
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
   localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          keyState_q;
   logic          keyState_d;
   logic [DW-1:0] dcnt_q;
   logic [DW-1:0] dcnt_d;
   holdState_e    state_q;
   holdState_e    state_d;
   logic [HW-1:0] hcnt_q;
   logic [HW-1:0] hcnt_d;
   logic          press_q;
   logic          press_d;
   logic          release_q;
   logic          release_d;
   logic          long_q;
   logic          long_d;
   logic          repeat_q;
   logic          repeat_d;
   logic          accept;
   logic          pressAccept;
   logic          releaseAccept;

   // All state registers; the released level is the reset value of the synchroniser.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         keyState_q <= 1'b0;
         dcnt_q     <= '0;
         state_q    <= IDLE;
         hcnt_q     <= '0;
         press_q    <= 1'b0;
         release_q  <= 1'b0;
         long_q     <= 1'b0;
         repeat_q   <= 1'b0;
      end else begin
         sync1_q    <= key_i;
         sync2_q    <= sync1_q;
         keyState_q <= keyState_d;
         dcnt_q     <= dcnt_d;
         state_q    <= state_d;
         hcnt_q     <= hcnt_d;
         press_q    <= press_d;
         release_q  <= release_d;
         long_q     <= long_d;
         repeat_q   <= repeat_d;
      end
   end

   // Any sample agreeing with the accepted level restarts the stable-time window.
   always_comb begin
      keyState_d = keyState_q;
      dcnt_d     = '0;
      accept     = 1'b0;
      if (sync2_q != keyState_q) begin
         if (dcnt_q == DEB_LAST) begin
            accept     = 1'b1;
            keyState_d = sync2_q;
         end else begin
            dcnt_d = dcnt_q + 1'b1;
         end
      end
   end

   assign pressAccept   = accept & sync2_q;
   assign releaseAccept = accept & ~sync2_q;

   always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q;
      case (state_q)
         IDLE: begin
            hcnt_d = '0;
            if (pressAccept) begin
               state_d = HELD;
            end
         end
         HELD: begin
            if (releaseAccept) begin
               state_d = IDLE;
               hcnt_d  = '0;
            end else if (hcnt_q == LONG_LAST) begin
               state_d = REPEAT;
               hcnt_d  = '0;
            end else begin
               hcnt_d = hcnt_q + 1'b1;
            end
         end
         REPEAT: begin
            if (releaseAccept) begin
               state_d = IDLE;
               hcnt_d  = '0;
            end else if (hcnt_q == REP_LAST) begin
               hcnt_d = '0;
            end else begin
               hcnt_d = hcnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            hcnt_d  = '0;
         end
      endcase
   end

   // A release accepted on a terminal-count cycle suppresses the long/repeat pulse.
   always_comb begin
      press_d   = pressAccept;
      release_d = releaseAccept;
      long_d    = (state_q == HELD) && !releaseAccept && (hcnt_q == LONG_LAST);
      repeat_d  = (state_q == REPEAT) && !releaseAccept && (hcnt_q == REP_LAST);
   end

   assign keyState_o     = keyState_q;
   assign pressPulse_o   = press_q;
   assign releasePulse_o = release_q;
   assign longPulse_o    = long_q;
   assign repeatPulse_o  = repeat_q;

   pulsesExclusive: assert property (@(posedge clk) disable iff (rst)
      $onehot0({press_q, release_q, long_q, repeat_q}));

endmodule

// File: rtl/multi_key_debounce.sv
// N-channel push-button conditioner: input polarity fix-up, one debounce channel
// per key, and optional suppression of auto-repeat pulses.
module multi_key_debounce
   import led_ctrl_pkg::*;
#(
   parameter int N_KEYS          = 4,
   parameter int DEBOUNCE_CYCLES = 1500000,
   parameter int LONG_CYCLES     = 50000000,
   parameter int REPEAT_CYCLES   = 10000000,
   parameter int REPEAT_EN       = 1,
   parameter int ACTIVE_LOW      = 0
) (
   input logic             clk,
   input logic             button1,
   multi_key_debounce_if.slave keys
);

   localparam logic INVERT = (ACTIVE_LOW != 0);

   logic [N_KEYS-1:0] keyIn;
   logic [N_KEYS-1:0] stateVec;
   logic [N_KEYS-1:0] pressVec;
   logic [N_KEYS-1:0] releaseVec;
   logic [N_KEYS-1:0] longVec;
   logic [N_KEYS-1:0] repeatVec;

   // Channels always see 1 = pressed, whatever the board wiring.
   assign keyIn = keys.key ^ {N_KEYS{INVERT}};

   for (genvar i = 0; i < N_KEYS; i++) begin : gChan
      key_debounce_chan #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .LONG_CYCLES    (LONG_CYCLES),
         .REPEAT_CYCLES  (REPEAT_CYCLES)
      ) uChan (
         .clk           (clk),
         .rst           (button1),
         .key_i         (keyIn[i]),
         .keyState_o    (stateVec[i]),
         .pressPulse_o  (pressVec[i]),
         .releasePulse_o(releaseVec[i]),
         .longPulse_o   (longVec[i]),
         .repeatPulse_o (repeatVec[i])
      );
   end

   assign keys.key_state     = stateVec;
   assign keys.press_pulse   = pressVec;
   assign keys.release_pulse = releaseVec;
   assign keys.long_pulse    = longVec;
   assign keys.repeat_pulse  = (REPEAT_EN != 0) ? repeatVec : '0;

endmodule

// File: tb/tb_multi_key_debounce.sv
// Self-checking bench for multi_key_debounce: directed key scenarios plus random
// bouncy keys, checked every cycle against a window/elapsed-time model.
module tb_multi_key_debounce;

   localparam int NK    = 2;
   localparam int DEB   = 8;
   localparam int LONGC = 40;
   localparam int REPC  = 10;

   logic          clk = 1'b0;
   logic          button1 = 1'b1;
   logic [NK-1:0] keyDrv = '0;
   bit            checkOn = 1'b0;
   int            compared = 0;
   int            mismatched = 0;

   multi_key_debounce_if #(.N_KEYS(NK)) ifA ();
   multi_key_debounce_if #(.N_KEYS(NK)) ifB ();

   assign ifA.key = keyDrv;
   assign ifB.key = keyDrv;

   multi_key_debounce #(
      .N_KEYS(NK), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONGC),
      .REPEAT_CYCLES(REPC), .REPEAT_EN(1), .ACTIVE_LOW(0)
   ) dutA (
      .clk    (clk),
      .button1(button1),
      .keys   (ifA)
   );

   multi_key_debounce #(
      .N_KEYS(NK), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONGC),
      .REPEAT_CYCLES(REPC), .REPEAT_EN(0), .ACTIVE_LOW(0)
   ) dutB (
      .clk    (clk),
      .button1(button1),
      .keys   (ifB)
   );

   always #5 clk = ~clk;

   // Reference model: a key level is accepted once the last DEB synchronised samples
   // all agree and differ from the current level; hold pulses follow from elapsed time.
   bit            syncA [NK];
   bit            syncB [NK];
   bit            hist [NK][DEB];
   int            histLen [NK];
   bit            ks [NK];
   int            pressAt [NK];
   int            cyc = 0;
   bit            mS;
   bit            mAll;
   bit            mAcc;
   int            mEl;
   logic [NK-1:0] expKs = '0;
   logic [NK-1:0] expPress = '0;
   logic [NK-1:0] expRel = '0;
   logic [NK-1:0] expLong = '0;
   logic [NK-1:0] expRep = '0;

   always @(posedge clk or posedge button1) begin
      if (button1) begin
         cyc = 0;
         for (int c = 0; c < NK; c++) begin
            syncA[c] = 1'b0;
            syncB[c] = 1'b0;
            histLen[c] = 0;
            ks[c] = 1'b0;
            pressAt[c] = 0;
            for (int j = 0; j < DEB; j++) hist[c][j] = 1'b0;
         end
         expKs = '0; expPress = '0; expRel = '0; expLong = '0; expRep = '0;
      end else begin
         cyc = cyc + 1;
         for (int c = 0; c < NK; c++) begin
            mS = syncB[c];
            syncB[c] = syncA[c];
            syncA[c] = keyDrv[c];
            for (int j = 0; j < DEB - 1; j++) hist[c][j] = hist[c][j+1];
            hist[c][DEB-1] = mS;
            if (histLen[c] < DEB) histLen[c] = histLen[c] + 1;
            mAll = (histLen[c] == DEB);
            for (int j = 0; j < DEB; j++) if (hist[c][j] != mS) mAll = 1'b0;
            mAcc = mAll && (mS != ks[c]);
            mEl = cyc - pressAt[c];
            expPress[c] = mAcc && mS;
            expRel[c]   = mAcc && !mS;
            expLong[c]  = !mAcc && ks[c] && (mEl == LONGC);
            expRep[c]   = !mAcc && ks[c] && (mEl > LONGC) && (((mEl - LONGC) % REPC) == 0);
            if (mAcc) ks[c] = mS;
            if (expPress[c]) pressAt[c] = cyc;
            expKs[c] = ks[c];
         end
      end
   end

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (checkOn) begin
         compared++;
         if ({ifA.key_state, ifA.press_pulse, ifA.release_pulse, ifA.long_pulse, ifA.repeat_pulse}
             !== {expKs, expPress, expRel, expLong, expRep}) begin
            mismatched++;
            $display("[TB] FAIL dutA t=%0t: got ks=%b pr=%b rl=%b lg=%b rp=%b, expected ks=%b pr=%b rl=%b lg=%b rp=%b",
                     $time, ifA.key_state, ifA.press_pulse, ifA.release_pulse, ifA.long_pulse,
                     ifA.repeat_pulse, expKs, expPress, expRel, expLong, expRep);
         end
         compared++;
         if ({ifB.key_state, ifB.press_pulse, ifB.release_pulse, ifB.long_pulse, ifB.repeat_pulse}
             !== {expKs, expPress, expRel, expLong, {NK{1'b0}}}) begin
            mismatched++;
            $display("[TB] FAIL dutB t=%0t: got ks=%b pr=%b rl=%b lg=%b rp=%b, expected ks=%b pr=%b rl=%b lg=%b rp=00",
                     $time, ifB.key_state, ifB.press_pulse, ifB.release_pulse, ifB.long_pulse,
                     ifB.repeat_pulse, expKs, expPress, expRel, expLong);
         end
      end
   end

   task automatic checkOutput(input string name, input int got, input int exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   // Per-kind first-occurrence index and count for one channel of dutA
   // (kind 0 press, 1 release, 2 long, 3 repeat).
   int obsFirst [4];
   int obsCount [4];

   task automatic observe(input int n, input int ch);
      logic [3:0] p;
      for (int k = 0; k < 4; k++) begin
         obsFirst[k] = -1;
         obsCount[k] = 0;
      end
      for (int i = 1; i <= n; i++) begin
         @(negedge clk);
         p = {ifA.repeat_pulse[ch], ifA.long_pulse[ch], ifA.release_pulse[ch], ifA.press_pulse[ch]};
         for (int k = 0; k < 4; k++) begin
            if (p[k]) begin
               obsCount[k]++;
               if (obsFirst[k] < 0) obsFirst[k] = i;
            end
         end
      end
   endtask

   task automatic applyStimulus(input logic [NK-1:0] keys, input int settle);
      keyDrv = keys;
      repeat (settle) @(negedge clk);
   endtask

   initial begin : watchdog
      #500000;
      mismatched++;
      $display("[TB] FAIL watchdog: got timeout at %0t, expected completion", $time);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   int lat;
   int nA;
   int nB;
   int lB;
   logic [NK-1:0] gotPress;
   int holdLeft [NK];

   initial begin : main
      $display("[TB] start");
      button1 = 1'b1;
      keyDrv  = '0;
      repeat (2) @(negedge clk);
      checkOutput("reset outputs dutA",
                  int'({ifA.key_state, ifA.press_pulse, ifA.release_pulse, ifA.long_pulse, ifA.repeat_pulse}), 0);
      checkOutput("reset outputs dutB",
                  int'({ifB.key_state, ifB.press_pulse, ifB.release_pulse, ifB.long_pulse, ifB.repeat_pulse}), 0);
      @(negedge clk);
      button1 = 1'b0;
      checkOn = 1'b1;
      repeat (2) @(negedge clk);

      // Clean press, then release.
      keyDrv[0] = 1'b1;
      observe(14, 0);
      checkOutput("T1 press latency", obsFirst[0], 10);
      checkOutput("T1 single press", obsCount[0], 1);
      checkOutput("T1 key_state", int'(ifA.key_state[0]), 1);
      keyDrv[0] = 1'b0;
      observe(14, 0);
      checkOutput("T1 release latency", obsFirst[1], 10);

      // Bouncy press then long hold with repeats.
      keyDrv[0] = 1'b1;
      observe(5, 0);
      nA = obsCount[0];
      keyDrv[0] = 1'b0;
      observe(3, 0);
      nA = nA + obsCount[0];
      checkOutput("T2 no press during bounce", nA, 0);
      keyDrv[0] = 1'b1;
      observe(110, 0);
      checkOutput("T2 press after final edge", obsFirst[0], 10);
      checkOutput("T2 single press", obsCount[0], 1);
      checkOutput("T3 long position", obsFirst[2], 50);
      checkOutput("T3 long count", obsCount[2], 1);
      checkOutput("T3 first repeat", obsFirst[3], 60);
      checkOutput("T3 repeat count", obsCount[3], 6);

      // Release lands on a repeat terminal count: release must win.
      keyDrv[0] = 1'b0;
      observe(40, 0);
      checkOutput("T4 release latency", obsFirst[1], 10);
      checkOutput("T4 no repeat after release", obsCount[3], 0);
      checkOutput("T4 no long after release", obsCount[2], 0);

      // Simultaneous press on both channels; repeat suppressed on dutB.
      keyDrv = 2'b11;
      lat = -1;
      gotPress = '0;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (ifA.press_pulse != '0) begin
            lat = i;
            gotPress = ifA.press_pulse;
            break;
         end
      end
      checkOutput("T5 press latency", lat, 10);
      checkOutput("T5 both press same cycle", int'(gotPress), 3);
      nA = 0; nB = 0; lB = 0;
      for (int i = 1; i <= 80; i++) begin
         @(negedge clk);
         if (ifA.repeat_pulse[0]) nA++;
         if (ifB.repeat_pulse != '0) nB++;
         if (ifB.long_pulse == 2'b11) lB++;
      end
      checkOutput("T5 dutA repeats", nA, 4);
      checkOutput("T5 dutB repeats", nB, 0);
      checkOutput("T5 dutB long both", lB, 1);

      // Asynchronous reset mid-hold.
      @(negedge clk);
      #2 button1 = 1'b1;
      #1;
      checkOutput("T6 dutA outputs in reset",
                  int'({ifA.key_state, ifA.press_pulse, ifA.release_pulse, ifA.long_pulse, ifA.repeat_pulse}), 0);
      checkOutput("T6 dutB outputs in reset",
                  int'({ifB.key_state, ifB.press_pulse, ifB.release_pulse, ifB.long_pulse, ifB.repeat_pulse}), 0);
      #1 button1 = 1'b0;
      observe(14, 0);
      checkOutput("T6 re-press latency", obsFirst[0], 10);
      checkOutput("T6 key_state after re-press", int'(ifA.key_state), 3);
      applyStimulus(2'b00, 20);

      // Random bouncy keys with occasional asynchronous resets.
      for (int c = 0; c < NK; c++) holdLeft[c] = 0;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         for (int c = 0; c < NK; c++) begin
            if (holdLeft[c] == 0) begin
               keyDrv[c] = 1'($urandom_range(0, 1));
               holdLeft[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : $urandom_range(8, 120);
            end else begin
               holdLeft[c] = holdLeft[c] - 1;
            end
         end
         if ($urandom_range(0, 999) == 0) begin
            #2 button1 = 1'b1;
            #2 button1 = 1'b0;
         end
      end

      repeat (3) @(negedge clk);
      checkOn = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
